tug_round_controller: RTL
=========================

// Module: tug_round_controller
// PURPOSE
//  Round sequencer for the tug-of-war game. It arms the push-button latch pair and opens a "go" window.
//  It reads the latched push/tie/right result and steps the rope position one LED toward the faster player.
//  It then clears the latches and declares a winner when the rope reaches either end.
//  It sits between the push-button latch block (drives its clear, reads push/tie/right) and the LED/display logic.
// PARAMETERS
//  POS_MAX      8   rope positions 0..POS_MAX; centre = POS_MAX/2 (POS_MAX even, >=2)
//  POS_W        4   width of pos, >= clog2(POS_MAX+1)
//  ARM_CYCLES  16   cycles in ARM before go window opens (>=1)
//  HOLD_CYCLES  4   cycles latches are held cleared after a scored push (>=1)
// PORTS
//  clk          in   1      system clock, all state on rising edge
//  rst          in   1      synchronous, active-low reset
//  start        in   1      start/restart game pulse; honoured only in IDLE or WIN
//  push         in   1      latch result: some player pressed first
//  tie          in   1      latch result: both latched
//  right        in   1      latch result: right player won the push
//  clear        out  1      clear to latch pair, active-high
//  go_led       out  1      go window open
//  pos          out  POS_W  rope position, 0 = left end, POS_MAX = right end
//  win_valid    out  1      game over, winner valid
//  win_right    out  1      winner is right player (valid with win_valid)
// BEHAVIOUR
//  - Reset: clk edge with rst==0 sets the following. Synchronous reset overrides everything, including mid-round.
//      state=IDLE, pos=POS_MAX/2, clear=1, go_led=0, win_valid=0, win_right=0, counter=0
//  - push/tie/right pass through a 2-flop synchronizer; the controller acts on the synced values (2-cycle latency).
//  - All outputs are registered. States: IDLE, ARM, GO, HOLD, WIN.
//  - IDLE: clear=1. When start==1: go to ARM, cnt<=ARM_CYCLES-1, pos<=POS_MAX/2.
//  - ARM: clear=1, go_led=0. cnt decrements each cycle. When cnt==0: go to GO (clear=0, go_led=1 next cycle).
//  - GO: clear=0, go_led=1. Wait for synced push.
//      push & tie      -> pos unchanged (tie takes priority over right)
//      push & right    -> pos<=pos+1
//      push & ~right   -> pos<=pos-1
//      Any push then goes to HOLD: cnt<=HOLD_CYCLES-1, clear<=1, go_led<=0 in the same edge as the pos update.
//  - HOLD: clear=1. cnt decrements. When cnt==0: if pos==0 or pos==POS_MAX go to WIN, else go to ARM (cnt<=ARM_CYCLES-1).
//  - WIN: clear=1, go_led=0, win_valid=1, win_right=(pos==POS_MAX); pos frozen.
//      start -> ARM with pos<=POS_MAX/2, win_valid<=0.
//  - start is ignored in ARM, GO and HOLD. pos never wraps, because WIN is entered at either end before any further step.
//  - Stale latch data: synced inputs still show set for 2 cycles after clear rises; HOLD_CYCLES>=1 plus ARM ignore them.
// CONFIGURATION
//  TUG_FALSE_START_EN
//   Defined:
//    - In ARM, clear=0 so the latches are live; go_led stays 0.
//    - A synced push in ARM is a false start: push&tie -> pos unchanged; push&right -> pos-1 (right penalised);
//      push&~right -> pos+1. Then HOLD, identical to GO scoring including the end check.
//   Undefined: ARM holds clear=1; early presses have no effect.
// STRUCTURE
//  - Shared header tug_defs.vh: state encodings (S_IDLE..S_WIN, 3 bits), CENTER=POS_MAX/2 helper macro.
//  - Sub-module sync2 (2-flop synchronizer, width parameter), instanced once, 3 bits wide.
//  - One FSM always block, one counter, one pos register; no combinational outputs.
// TESTING
//  1 Reset: rst=0 two cycles -> pos=4, clear=1, go_led=0, win_valid=0. start ignored while rst=0.
//  2 start, then right push in GO -> go_led rises after 16 ARM cycles; 2 cycles after push, pos 4->5;
//    clear=1 for HOLD_CYCLES; back to ARM.
//  3 Four consecutive left wins from centre -> pos 4,3,2,1,0; after HOLD, win_valid=1, win_right=0; start -> pos=4.
//  4 Tie in GO (push=tie=right=1) -> pos unchanged, HOLD then ARM.
//  5 rst=0 asserted mid-GO at pos=6 -> next edge IDLE, pos=4, clear=1, go_led=0.
//  6 With TUG_FALSE_START_EN: right press 5 cycles into ARM -> pos 4->3, HOLD, ARM restarts.
//    Without TUG_FALSE_START_EN: same stimulus -> pos stays 4, GO opens on time.

Source files
------------

// File: rtl/tug_round_controller_pkg.sv
// Shared types for the tug-of-war round controller: state encoding and rope-centre helper.
package tug_round_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_GO   = 3'd2,
    S_HOLD = 3'd3,
    S_WIN  = 3'd4
  } state_t;

  function automatic int center(input int pos_max);
    return pos_max / 2;
  endfunction

endpackage

// File: rtl/tug_round_controller_sync2.sv
// Two-flop synchronizer for the push-button latch results, cleared by synchronous active-low reset.
module tug_round_controller_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two-stage resynchronisation of the asynchronous latch outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tug_round_controller.sv
// Tug-of-war round sequencer: arms the latches, opens the go window, scores pushes, declares a winner.
// Optional feature macro: TUG_FALSE_START_EN (latches live during ARM, early presses penalised).
module tug_round_controller
  import tug_round_controller_pkg::*;
#(
  parameter int POS_MAX     = 8,
  parameter int POS_W       = 4,
  parameter int ARM_CYCLES  = 16,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             push,
  input  logic             tie,
  input  logic             right,
  output logic             clear,
  output logic             go_led,
  output logic [POS_W-1:0] pos,
  output logic             win_valid,
  output logic             win_right
);

  localparam int CNT_MAX = (ARM_CYCLES > HOLD_CYCLES) ? ARM_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [POS_W-1:0] POS_CENTER = POS_W'(center(POS_MAX));
  localparam logic [POS_W-1:0] POS_TOP    = POS_W'(POS_MAX);
  localparam logic [CNT_W-1:0] ARM_LOAD   = CNT_W'(ARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [POS_W-1:0] pos_n;
  logic             clear_n, go_led_n, win_valid_n, win_right_n;
  logic [2:0]       sync_bits;
  logic             s_push, s_tie, s_right;

  tug_round_controller_sync2 #(.W(3)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({push, tie, right}),
    .q   (sync_bits)
  );

  assign s_push  = sync_bits[2];
  assign s_tie   = sync_bits[1];
  assign s_right = sync_bits[0];

  // Moves the rope one step toward the favoured side; a tie leaves it alone and the ends never wrap.
  function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] p,
                                                input logic is_tie,
                                                input logic up);
    logic [POS_W-1:0] r;
    r = p;
    if (is_tie) begin
      r = p;
    end else if (up) begin
      if (p != POS_TOP) r = p + POS_W'(1);
      else              r = p;
    end else begin
      if (p != {POS_W{1'b0}}) r = p - POS_W'(1);
      else                    r = p;
    end
    return r;
  endfunction

  // Next-state, counter, rope position and registered-output decode.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    pos_n       = pos;
    clear_n     = 1'b1;
    go_led_n    = 1'b0;
    win_valid_n = 1'b0;
    win_right_n = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_ARM;
          cnt_n   = ARM_LOAD;
          pos_n   = POS_CENTER;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_ARM: begin
`ifdef TUG_FALSE_START_EN
        if (s_push) begin
          // False start: the early presser loses the step, so direction is inverted.
          state_n = S_HOLD;
          cnt_n   = HOLD_LOAD;
          pos_n   = step_pos(pos, s_tie, ~s_right);
        end else if (cnt == {CNT_W{1'b0}}) begin
          state_n = S_GO;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
`else
        if (cnt == {CNT_W{1'b0}}) begin
          state_n = S_GO;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
`endif
      end
      S_GO: begin
        if (s_push) begin
          state_n = S_HOLD;
          cnt_n   = HOLD_LOAD;
          pos_n   = step_pos(pos, s_tie, s_right);
        end else begin
          state_n = S_GO;
        end
      end
      S_HOLD: begin
        if (cnt == {CNT_W{1'b0}}) begin
          if ((pos == {POS_W{1'b0}}) || (pos == POS_TOP)) begin
            state_n = S_WIN;
          end else begin
            state_n = S_ARM;
            cnt_n   = ARM_LOAD;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_WIN: begin
        if (start) begin
          state_n = S_ARM;
          cnt_n   = ARM_LOAD;
          pos_n   = POS_CENTER;
        end else begin
          state_n = S_WIN;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = {CNT_W{1'b0}};
        pos_n   = POS_CENTER;
      end
    endcase

    // Outputs follow the state being entered so they are valid the cycle after the edge.
    if (state_n == S_GO) begin
      clear_n  = 1'b0;
      go_led_n = 1'b1;
    end else begin
      clear_n  = 1'b1;
      go_led_n = 1'b0;
    end
`ifdef TUG_FALSE_START_EN
    if (state_n == S_ARM) begin
      clear_n = 1'b0;
    end else begin
      clear_n = clear_n;
    end
`endif
    if (state_n == S_WIN) begin
      win_valid_n = 1'b1;
      win_right_n = (pos_n == POS_TOP);
    end else begin
      win_valid_n = 1'b0;
      win_right_n = 1'b0;
    end
  end

  // State, counter, rope position and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= {CNT_W{1'b0}};
      pos       <= POS_CENTER;
      clear     <= 1'b1;
      go_led    <= 1'b0;
      win_valid <= 1'b0;
      win_right <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pos       <= pos_n;
      clear     <= clear_n;
      go_led    <= go_led_n;
      win_valid <= win_valid_n;
      win_right <= win_right_n;
    end
  end

endmodule
